// File: rtl/mtr_pkg.sv
// rtl/mtr_pkg.sv - shared widths, constants and types for the motor PWM driver
package mtr_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] DUTY_MID    = 11'h400;
  localparam logic [PWM_W-1:0] PERIOD_LAST = 11'h7FF;

  typedef logic signed [PWM_W-1:0] spd_t;
  typedef logic        [PWM_W-1:0] duty_t;

  // Adding the midpoint flips the sign bit: -1024..+1023 becomes 0..2047.
  function automatic duty_t spd_to_duty(input spd_t spd);
    return duty_t'(spd) + DUTY_MID;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// rtl/pwm_chan.sv - one H-bridge channel: buffered duty, compare, dead-time and output flops
module pwm_chan
  import mtr_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic  clk,
  input  logic  rst,
  input  duty_t cnt,
  input  spd_t  spd,
  input  logic  load,
  output logic  pwm1,
  output logic  pwm2
);

  localparam logic [7:0] RUN_MAX = 8'(NONOVERLAP);

  duty_t      duty_q, duty_d;
  logic       raw;
  logic       raw_prev_q, raw_prev_d;
  logic [7:0] run_q, run_d;
  logic       settled;
  logic       pwm1_q, pwm1_d;
  logic       pwm2_q, pwm2_d;

  assign raw = (cnt < duty_q);

  always_comb begin
    duty_d     = load ? spd_to_duty(spd) : duty_q;
    raw_prev_d = raw;
    if (raw != raw_prev_q) begin
      run_d = '0;
    end else if (run_q == RUN_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + 8'd1;
    end
    // The run count includes the current sample, so each output rises N+1 clocks after its raw edge.
    settled = (run_d == RUN_MAX);
    pwm1_d  = raw & settled;
    pwm2_d  = ~raw & settled;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q     <= DUTY_MID;
      raw_prev_q <= 1'b0;
      run_q      <= '0;
      pwm1_q     <= 1'b0;
      pwm2_q     <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      raw_prev_q <= raw_prev_d;
      run_q      <= run_d;
      pwm1_q     <= pwm1_d;
      pwm2_q     <= pwm2_d;
    end
  end

  assign pwm1 = pwm1_q;
  assign pwm2 = pwm2_q;

endmodule

// File: rtl/motor_pwm_drv.sv
// rtl/motor_pwm_drv.sv - shared 2048-clock period counter, period sync pulse and two PWM channels
module motor_pwm_drv
  import mtr_pkg::*;
#(
  parameter int NONOVERLAP = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [PWM_W-1:0] lft_spd,
  input  logic signed [PWM_W-1:0] rght_spd,
  output logic                    lft_pwm1,
  output logic                    lft_pwm2,
  output logic                    rght_pwm1,
  output logic                    rght_pwm2,
  output logic                    pwm_sync
);

  duty_t cnt_q, cnt_d;
  logic  load;
  logic  pwm_sync_q, pwm_sync_d;

  // Duties reload on the last clock of a period so a new command starts cleanly at cnt==0.
  always_comb begin
    cnt_d      = cnt_q + 11'd1;
    load       = (cnt_q == PERIOD_LAST);
    pwm_sync_d = load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      pwm_sync_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      pwm_sync_q <= pwm_sync_d;
    end
  end

  assign pwm_sync = pwm_sync_q;

  pwm_chan #(
    .NONOVERLAP(NONOVERLAP)
  ) u_lft (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .spd  (lft_spd),
    .load (load),
    .pwm1 (lft_pwm1),
    .pwm2 (lft_pwm2)
  );

  pwm_chan #(
    .NONOVERLAP(NONOVERLAP)
  ) u_rght (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt_q),
    .spd  (rght_spd),
    .load (load),
    .pwm1 (rght_pwm1),
    .pwm2 (rght_pwm2)
  );

endmodule

// File: tb/tb_motor_pwm_drv.sv
// tb/tb_motor_pwm_drv.sv - self-checking bench for motor_pwm_drv
module tb_motor_pwm_drv;

  localparam int N      = 32;
  localparam int PERIOD = 2048;
  localparam int NV     = 8;

  typedef struct {
    int l;
    int r;
    int apply;
    int l1;
    int l2;
    int r1;
    int r2;
  } vec_t;

  typedef struct {
    int l1;
    int l2;
    int r1;
    int r2;
  } exp_t;

  logic              clk;
  logic              rst;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic              lft_pwm1;
  logic              lft_pwm2;
  logic              rght_pwm1;
  logic              rght_pwm2;
  logic              pwm_sync;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t e;
  vec_t vecs[NV];
  bit   mon_en = 0;
  bit   primed = 0;
  int   cyc = 0;
  int   hl1 = 0, hl2 = 0, hr1 = 0, hr2 = 0, lol = 0, lor = 0;
  int   lrun_l = 0, lrun_r = 0;

  motor_pwm_drv #(
    .NONOVERLAP(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .lft_pwm1  (lft_pwm1),
    .lft_pwm2  (lft_pwm2),
    .rght_pwm1 (rght_pwm1),
    .rght_pwm2 (rght_pwm2),
    .pwm_sync  (pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_sync();
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (pwm_sync === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_sync: no pwm_sync within 2100 cycles");
  endtask

  // Per-cycle monitor: overlap, dead time, and per-period high/low tallies popped against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("overlap_lft", 32'(lft_pwm1 & lft_pwm2), 0);
      check("overlap_rght", 32'(rght_pwm1 & rght_pwm2), 0);
      if (lft_pwm1 | lft_pwm2) begin
        if (lrun_l > 0) check("deadtime_lft", 32'(lrun_l >= N), 1);
        lrun_l = 0;
      end else begin
        lrun_l++;
      end
      if (rght_pwm1 | rght_pwm2) begin
        if (lrun_r > 0) check("deadtime_rght", 32'(lrun_r >= N), 1);
        lrun_r = 0;
      end else begin
        lrun_r++;
      end
      cyc++;
      hl1 += int'(lft_pwm1);
      hl2 += int'(lft_pwm2);
      hr1 += int'(rght_pwm1);
      hr2 += int'(rght_pwm2);
      lol += int'(!(lft_pwm1 | lft_pwm2));
      lor += int'(!(rght_pwm1 | rght_pwm2));
      if (pwm_sync) begin
        if (primed) begin
          check("period_len", cyc, PERIOD);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: window ended with no expected entry");
          end else begin
            e = sb_q.pop_front();
            check("lft_pwm1_high", hl1, e.l1);
            check("lft_pwm2_high", hl2, e.l2);
            check("lft_both_low", lol, PERIOD - e.l1 - e.l2);
            check("rght_pwm1_high", hr1, e.r1);
            check("rght_pwm2_high", hr2, e.r2);
            check("rght_both_low", lor, PERIOD - e.r1 - e.r2);
          end
        end
        primed = 1;
        cyc = 0;
        hl1 = 0; hl2 = 0; hr1 = 0; hr2 = 0; lol = 0; lor = 0;
      end
    end
  end

  initial begin
    int first_l, first_r, hi, sync_at;

    vecs[0] = '{l:    0, r:    0, apply:   0, l1:  992, l2:  992, r1:  992, r2:  992};
    vecs[1] = '{l:  512, r: -512, apply:   5, l1: 1504, l2:  480, r1:  480, r2: 1504};
    vecs[2] = '{l:-1024, r: 1023, apply:   5, l1:    0, l2: 2048, r1: 2015, r2:    0};
    vecs[3] = '{l: 1023, r:    0, apply:   5, l1: 2015, l2:    0, r1:  992, r2:  992};
    vecs[4] = '{l: -400, r:  300, apply:   5, l1:  592, l2: 1392, r1: 1292, r2:  692};
    vecs[5] = '{l:-1000, r: 1000, apply:   5, l1:    0, l2: 1992, r1: 1992, r2:    0};
    vecs[6] = '{l:    0, r:    0, apply:   5, l1:  992, l2:  992, r1:  992, r2:  992};
    vecs[7] = '{l:  512, r:    0, apply: 700, l1: 1504, l2:  480, r1:  992, r2:  992};

    rst      = 1'b1;
    lft_spd  = 11'(vecs[0].l);
    rght_spd = 11'(vecs[0].r);
    repeat (3) @(negedge clk);
    check("rst_lft_pwm1", 32'(lft_pwm1), 0);
    check("rst_lft_pwm2", 32'(lft_pwm2), 0);
    check("rst_rght_pwm1", 32'(rght_pwm1), 0);
    check("rst_rght_pwm2", 32'(rght_pwm2), 0);
    check("rst_pwm_sync", 32'(pwm_sync), 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_sync();

    for (int i = 0; i < NV; i++) begin
      sb_q.push_back('{l1: vecs[i].l1, l2: vecs[i].l2, r1: vecs[i].r1, r2: vecs[i].r2});
      if (i + 1 < NV) begin
        repeat (vecs[i+1].apply) @(negedge clk);
        lft_spd  = 11'(vecs[i+1].l);
        rght_spd = 11'(vecs[i+1].r);
      end
      wait_sync();
    end
    @(posedge clk);
    check("sb_drained", sb_q.size(), 0);
    mon_en = 1'b0;

    // Asynchronous reset while lft_pwm1 is high, then time the restart.
    repeat (100) @(negedge clk);
    check("pre_rst_lft_pwm1", 32'(lft_pwm1), 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_lft_pwm1", 32'(lft_pwm1), 0);
    check("async_rst_lft_pwm2", 32'(lft_pwm2), 0);
    check("async_rst_rght_pwm1", 32'(rght_pwm1), 0);
    check("async_rst_rght_pwm2", 32'(rght_pwm2), 0);
    check("async_rst_pwm_sync", 32'(pwm_sync), 0);
    repeat (3) @(negedge clk);
    rst     = 1'b0;
    first_l = -1;
    first_r = -1;
    hi      = 0;
    sync_at = -1;
    for (int j = 1; j <= PERIOD; j++) begin
      @(negedge clk);
      if (lft_pwm1 && first_l < 0) first_l = j;
      if (rght_pwm1 && first_r < 0) first_r = j;
      hi += int'(lft_pwm1);
      if (pwm_sync && sync_at < 0) sync_at = j;
    end
    check("restart_lft_rise", first_l, N + 1);
    check("restart_rght_rise", first_r, N + 1);
    check("restart_lft_high_reset_duty", hi, 1024 - N);
    check("restart_first_sync", sync_at, PERIOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
